// File: rtl/seq_mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// Results are {result_high, result_low}: product halves, or remainder/quotient.
module seq_mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_low,
    output logic [WIDTH-1:0] result_high
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, FINISH} state_t;

    state_t                   state;
    logic [CW-1:0]            count;
    logic signed [WIDTH-1:0]  a_reg;
    logic signed [WIDTH-1:0]  b_reg;
    logic                     mode_div;
    logic                     sign_a;
    logic                     sign_q;
    // acc doubles as the Booth accumulator and the divide partial remainder;
    // q doubles as the Booth multiplier and the quotient shift register.
    logic signed [WIDTH:0]    acc;
    logic [WIDTH-1:0]         q;
    logic                     q_m1;
    logic [WIDTH-1:0]         mcand;

    logic signed [WIDTH:0]    m_ext;
    logic signed [WIDTH:0]    booth_sum;
    logic [WIDTH:0]           div_shift;
    logic [WIDTH:0]           div_trial;
    logic signed [WIDTH:0]    next_acc;
    logic [WIDTH-1:0]         next_q;
    logic                     next_q_m1;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + ONE) : v;
    endfunction

    always_comb begin
        m_ext     = {mcand[WIDTH-1], mcand};
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand};
        next_acc  = acc;
        next_q    = q;
        next_q_m1 = q_m1;
        if (mode_div) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!div_trial[WIDTH]) begin
                next_acc = div_trial;
                next_q   = {q[WIDTH-2:0], 1'b1};
            end else begin
                next_acc = div_shift;
                next_q   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_acc  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            next_q    = {booth_sum[0], q[WIDTH-1:1]};
            next_q_m1 = q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mode_div    <= 1'b0;
            sign_a      <= 1'b0;
            sign_q      <= 1'b0;
            acc         <= '0;
            q           <= '0;
            q_m1        <= 1'b0;
            mcand       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_low  <= '0;
            result_high <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        mode_div <= div_sel;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    q_m1  <= 1'b0;
                    count <= CW'(WIDTH);
                    if (mode_div) begin
                        sign_a <= a_reg[WIDTH-1];
                        sign_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                        q      <= neg_if(a_reg, a_reg[WIDTH-1]);
                        mcand  <= neg_if(b_reg, b_reg[WIDTH-1]);
                    end else begin
                        q     <= b_reg;
                        mcand <= a_reg;
                    end
                    state <= RUN;
                end
                RUN: begin
                    acc   <= next_acc;
                    q     <= next_q;
                    q_m1  <= next_q_m1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (!mode_div) begin
                        result_low  <= q;
                        result_high <= acc[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end else if (b_reg == '0) begin
                        result_low  <= '1;
                        result_high <= a_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        // Truncating division: remainder follows the dividend's sign.
                        result_low  <= neg_if(q, sign_q);
                        result_high <= neg_if(acc[WIDTH-1:0], sign_a);
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Scoreboard bench for seq_mul_div_unit: directed MUL/DIV vectors, ignored
// restart, and mid-operation reset.
module tb_seq_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         div_sel;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] result_low;
    logic [W-1:0] result_high;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t         sb[$];
    int           checks     = 0;
    int           failures   = 0;
    int           done_seen  = 0;
    logic [W-1:0] prev_lo    = '0;

    always #5 clk = ~clk;

    seq_mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .div_sel     (div_sel),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result_low  (result_low),
        .result_high (result_high)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result_low", {32'd0, result_low}, {32'd0, e.lo});
                check("result_high", {32'd0, result_high}, {32'd0, e.hi});
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
            end
        end
    end

    task automatic run_op(input logic dsel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input logic exp_dbz, input int glitch_at, input int reset_at);
        exp_t e;
        int   lat;
        int   done_before;
        logic window_ok;
        lat         = 0;
        window_ok   = 1'b1;
        done_before = done_seen;
        if (reset_at == 0) begin
            e.lo  = exp_lo;
            e.hi  = exp_hi;
            e.dbz = exp_dbz;
            sb.push_back(e);
        end
        @(negedge clk);
        start   = 1'b1;
        div_sel = dsel;
        A       = a;
        B       = b;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start   = 1'b0;
                A       = ~a;
                B       = ~b;
                div_sel = ~dsel;
            end
            if (reset_at != 0 && k == reset_at + 1) begin
                reset = 1'b0;
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_done", {63'd0, done}, 64'd0);
                check("rst_low", {32'd0, result_low}, 64'd0);
                check("rst_high", {32'd0, result_high}, 64'd0);
                prev_lo = '0;
                repeat (40) @(posedge clk);
                #1;
                check("rst_no_done", done_seen - done_before, 64'd0);
                return;
            end
            if (k == 10) check("hold_low", {32'd0, result_low}, {32'd0, prev_lo});
            if (done === 1'b1 && lat == 0) lat = k;
            if (busy !== (k <= 34)) window_ok = 1'b0;
            if (done !== (k == 35)) window_ok = 1'b0;
            if (k == glitch_at) begin
                start = 1'b1;
                A     = 32'd5;
                B     = 32'd5;
            end
            if (glitch_at != 0 && k == glitch_at + 1) start = 1'b0;
            if (reset_at != 0 && k == reset_at) reset = 1'b1;
        end
        check("latency", lat, 64'd35);
        check("busy_done_window", {63'd0, window_ok}, 64'd1);
        if (glitch_at != 0) repeat (40) @(posedge clk);
        #1;
        check("done_count", done_seen - done_before, 64'd1);
        prev_lo = exp_lo;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        div_sel = 1'b0;
        A       = '0;
        B       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        check("reset_low", {32'd0, result_low}, 64'd0);
        check("reset_high", {32'd0, result_high}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(1'b0, 32'hF000_0000, 32'h00FF_0000, 32'h0000_0000, 32'hFFF0_1000, 1'b0, 0, 0);
        run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 0, 0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 0, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op(1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 0, 0);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0, 0);
        run_op(1'b1, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 0, 0);
        run_op(1'b0, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000, 32'h0000_0000, 1'b0, 10, 0);
        run_op(1'b1, 32'd1000,      32'd3,         32'd0,         32'd0,         1'b0, 0, 20);
        run_op(1'b0, 32'd6,         32'd7,         32'd42,        32'd0,         1'b0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
